// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: shared constants and FSM encoding for the UART RX deframer
package axis_uart_pkg;
  localparam logic [7:0] SOF_DEF = 8'h7E;
  localparam int MAX_LEN_DEF = 16;
  localparam int LEN_W = $clog2(MAX_LEN_DEF + 1);
  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/axis_uart_frame_buf.sv
// axis_uart_frame_buf: payload register array, sync write, async read, no data reset
module axis_uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_uart_rx_deframer.sv
// axis_uart_rx_deframer: parses SOF/LEN/payload/XOR frames, forwards only good frames on AXI-Stream
module axis_uart_rx_deframer
  import axis_uart_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [8:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [4:0]  s_axis_terror,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] frame_ok_count,
  output logic [31:0] frame_err_count,
  output logic        busy
);
  localparam int LW = len_w(MAX_LEN);
  localparam int AW = $clog2(MAX_LEN);
  state_t state, state_n;
  logic rdy_en, acc, bad, active, timed_out, err_evt, ok_evt, hs, wr_en, unused_ok;
  logic [LW-1:0] len, wr_ptr, rd_ptr;
  logic [7:0] chk, b, rd_data;
  logic [31:0] timer;
  assign unused_ok = s_axis_tdata[8];
  assign b = s_axis_tdata[7:0];
  assign bad = |s_axis_terror;
  assign s_axis_tready = rdy_en && state != DRAIN;
  assign acc = s_axis_tvalid && s_axis_tready;
  assign active = state inside {LEN, PAYLOAD, CHECK};
  assign timed_out = TIMEOUT_CYCLES != 0 && active && !acc && timer == 32'(TIMEOUT_CYCLES - 1);
  assign m_axis_tvalid = state == DRAIN;
  assign m_axis_tdata = m_axis_tvalid ? rd_data : 8'h00;
  assign m_axis_tlast = m_axis_tvalid && rd_ptr == len - LW'(1);
  assign hs = m_axis_tvalid && m_axis_tready;
  assign ok_evt = hs && m_axis_tlast;
  assign wr_en = state == PAYLOAD && acc && !bad;
  assign busy = state != HUNT;
  always_comb begin
    state_n = state;
    err_evt = timed_out;
    case (state)
      HUNT:    if (acc && !bad && b == SOF_BYTE) state_n = LEN;
      LEN:     if (acc) begin
                 err_evt = bad || b == 8'h00 || {1'b0, b} > 9'(MAX_LEN);
                 state_n = PAYLOAD;
               end
      PAYLOAD: if (acc) begin
                 err_evt = bad;
                 state_n = wr_ptr == len - LW'(1) ? CHECK : PAYLOAD;
               end
      CHECK:   if (acc) begin
                 err_evt = bad || b != chk;
                 state_n = DRAIN;
               end
      DRAIN:   if (ok_evt) state_n = HUNT;
      default: state_n = HUNT;
    endcase
    if (err_evt) state_n = HUNT;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= HUNT;
    else state <= state_n;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en <= 1'b0;
      len <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      chk <= '0;
      timer <= '0;
      frame_ok_count <= '0;
      frame_err_count <= '0;
    end else begin
      rdy_en <= 1'b1;
      timer <= (acc || !active || state_n == HUNT) ? '0 : timer + 32'd1;
      if (state == LEN && acc && !err_evt) begin
        len <= LW'(b);
        chk <= b;
        wr_ptr <= '0;
      end
      if (wr_en) begin
        chk <= chk ^ b;
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (state == CHECK && acc && !err_evt) rd_ptr <= '0;
      if (hs) rd_ptr <= rd_ptr + LW'(1);
      frame_ok_count <= frame_ok_count + 32'(ok_evt && !(&frame_ok_count));
      frame_err_count <= frame_err_count + 32'(err_evt && !(&frame_err_count));
    end
  end
  axis_uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk  (aclk),
    .we   (wr_en),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(b),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );
endmodule
